arbitro_acciones: RTL and testbench
===================================

Name: arbitro_acciones

Overview:
- Arbitrates between the food and medicine action requests, which are one-cycle pulses from the 5-second hold detectors.
- Grants a single shared action slot (animation, dispense and level update) to one requester at a time, using round-robin priority.
- Holds each grant for a fixed duration, then enforces a cooldown before the next grant.
- Sits between the mode logic and the pet state machine, and drives the Activo_Comida / Activo_Medicina handshake.

Parameters:
- DURACION, 100, number of cycles a grant stays asserted (>=1).
- ENFRIAMIENTO, 20, number of cooldown cycles after a grant (>=1).
- NIVEL_MAX, 3, level value at which a request is rejected (2-bit levels).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Req_Comida  input  1  one-cycle food request pulse.
- Req_Medicina  input  1  one-cycle medicine request pulse.
- Nivel_Comida  input  2  current food level.
- Nivel_Medicina  input  2  current medicine level.
- Activo_Comida  output  1  food grant, high for DURACION cycles.
- Activo_Medicina  output  1  medicine grant, high for DURACION cycles.
- Ocupado  output  1  high whenever the state is not IDLE.
- Fin_Accion  output  1  one-cycle pulse when a grant ends.
- Rechazo  output  1  one-cycle pulse when a request is refused at max level.
- Pendiente_Comida  output  1  latched food request waiting for service.
- Pendiente_Medicina  output  1  latched medicine request waiting for service.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; state IDLE; counter 0; ultimo = MEDICINA, so food wins the first tie.
  - Reset asserted mid-action drops the grant and clears both pending flags at that edge.
  - No Fin_Accion is issued on reset.
- Request latching, at each edge:
  - If Req_X=1 and Nivel_X < NIVEL_MAX, Pendiente_X is set to 1.
  - If Req_X=1 and Nivel_X == NIVEL_MAX, Pendiente_X is unchanged and Rechazo=1 for the next cycle only.
  - When both requests are rejected in the same cycle, a single Rechazo pulse is produced.
  - A repeated request while Pendiente_X=1 has no further effect; requests are not counted.
  - Requests are accepted in every state, including while X itself is active.
- State machine, states IDLE, ACTIVO, ENFRIAR:
  - IDLE, no pending flags: remain in IDLE.
  - IDLE, exactly one pending flag: grant that requester.
  - IDLE, both pending: grant the requester that is not ultimo.
  - On a grant edge: next state ACTIVO, Activo_X=1, chosen Pendiente_X cleared, ultimo <= X, counter <= DURACION-1.
  - If Req_X arrives on the same edge that X is granted, Pendiente_X stays 1, so X is served again later.
  - ACTIVO: exactly one Activo output is high; it stays high for exactly DURACION cycles and the counter decrements.
  - ACTIVO, when the counter reaches 0: next state ENFRIAR, both Activo outputs 0, Fin_Accion=1 for that first ENFRIAR cycle, counter <= ENFRIAMIENTO-1.
  - ENFRIAR: lasts ENFRIAMIENTO cycles, then IDLE. New requests still latch but are not granted.
- Latency:
  - A request sampled at edge E0 makes Pendiente high after E0.
  - If the block is IDLE, the grant is high after E1, i.e. 2 edges from request to Activo.
- Grant spacing: the minimum spacing between the rising edges of consecutive grants is DURACION + ENFRIAMIENTO + 1 cycles, which includes 1 IDLE cycle.
- Invariants:
  - Activo_Comida and Activo_Medicina are never both 1.
  - Ocupado = (state != IDLE), registered.
- Counter width: clog2(max(DURACION, ENFRIAMIENTO)+1) bits; no wrap-around is allowed.
- Levels: the level inputs are checked only at the request edge. A level change during a grant does not abort the grant.

Test Plan (DURACION=4, ENFRIAMIENTO=2, NIVEL_MAX=3):
1. Reset held 3 cycles, then released -> all outputs 0 and Ocupado=0. Req_Comida pulse with Nivel_Comida=1 -> Pendiente_Comida high 1 cycle, then Activo_Comida high exactly 4 cycles, Fin_Accion pulse, Ocupado low after 2 cooldown cycles.
2. Req_Comida and Req_Medicina in the same cycle, both levels 0 -> food granted first for 4 cycles; medicine granted 7 cycles after the food grant rose; Activo outputs never overlap.
3. Req_Medicina with Nivel_Medicina=3 -> Rechazo=1 for exactly 1 cycle; Pendiente_Medicina stays 0; Ocupado stays 0.
4. Req_Comida during a food grant (cycle 2 of 4) -> after cooldown and 1 IDLE cycle, a second 4-cycle food grant; two Fin_Accion pulses in total.
5. Reset asserted in cycle 3 of a medicine grant with food pending -> next cycle Activo_Medicina=0, Pendiente_Comida=0, Ocupado=0, no Fin_Accion; no grant follows until a new request.
6. Three back-to-back tie cycles, each followed by service -> grants alternate food, medicine, food (round-robin check).

Source files
------------

// File: rtl/arbitro_acciones_if.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_acciones_if
// Description : Request/grant bundle between the mode logic (master) and the
//               food/medicine action arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface arbitro_acciones_if;
   logic       Req_Comida;
   logic       Req_Medicina;
   logic [1:0] Nivel_Comida;
   logic [1:0] Nivel_Medicina;
   logic       Activo_Comida;
   logic       Activo_Medicina;
   logic       Ocupado;
   logic       Fin_Accion;
   logic       Rechazo;
   logic       Pendiente_Comida;
   logic       Pendiente_Medicina;

   modport master (
      output Req_Comida, Req_Medicina, Nivel_Comida, Nivel_Medicina,
      input  Activo_Comida, Activo_Medicina, Ocupado, Fin_Accion, Rechazo,
             Pendiente_Comida, Pendiente_Medicina
   );

   modport slave (
      input  Req_Comida, Req_Medicina, Nivel_Comida, Nivel_Medicina,
      output Activo_Comida, Activo_Medicina, Ocupado, Fin_Accion, Rechazo,
             Pendiente_Comida, Pendiente_Medicina
   );
endinterface
`default_nettype wire

// File: rtl/arbitro_acciones.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_acciones
// Description : Round-robin arbiter granting one shared action slot to food
//               or medicine for DURACION cycles, followed by a cooldown.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_acciones #(
   parameter int DURACION     = 100,
   parameter int ENFRIAMIENTO = 20,
   parameter int NIVEL_MAX    = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   arbitro_acciones_if.slave    bus
);

   localparam int MAX_CUENTA = (DURACION > ENFRIAMIENTO) ? DURACION : ENFRIAMIENTO;
   localparam int CW         = (MAX_CUENTA > 1) ? $clog2(MAX_CUENTA + 1) : 1;

   localparam logic [CW-1:0] c_dur       = CW'(DURACION - 1);
   localparam logic [CW-1:0] c_enf       = CW'(ENFRIAMIENTO - 1);
   localparam logic [CW-1:0] c_uno       = CW'(1);
   localparam logic [1:0]    c_nivel_max = 2'(NIVEL_MAX);
   localparam logic          c_ult_med   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVO  = 2'd1,
      ST_ENFRIAR = 2'd2
   } estado_t;

   estado_t       state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ultimo_q, ultimo_d;
   logic          act_c_q, act_c_d;
   logic          act_m_q, act_m_d;
   logic          pend_c_q, pend_c_d;
   logic          pend_m_q, pend_m_d;
   logic          fin_q, fin_d;
   logic          rech_q, rech_d;
   logic          ocup_q, ocup_d;

   logic acepta_c, acepta_m, rechaza_c, rechaza_m;
   logic grant_c, grant_m;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ultimo_d = ultimo_q;
      act_c_d  = act_c_q;
      act_m_d  = act_m_q;
      fin_d    = 1'b0;
      grant_c  = 1'b0;
      grant_m  = 1'b0;

      // Levels are only judged on the request edge itself.
      acepta_c  = bus.Req_Comida   && (bus.Nivel_Comida   <  c_nivel_max);
      acepta_m  = bus.Req_Medicina && (bus.Nivel_Medicina <  c_nivel_max);
      rechaza_c = bus.Req_Comida   && (bus.Nivel_Comida   >= c_nivel_max);
      rechaza_m = bus.Req_Medicina && (bus.Nivel_Medicina >= c_nivel_max);

      case (state_q)
         ST_IDLE: begin
            if (pend_c_q && (!pend_m_q || (ultimo_q == c_ult_med))) begin
               grant_c = 1'b1;
            end else if (pend_m_q) begin
               grant_m = 1'b1;
            end
            if (grant_c || grant_m) begin
               state_d  = ST_ACTIVO;
               cnt_d    = c_dur;
               ultimo_d = grant_m;
               act_c_d  = grant_c;
               act_m_d  = grant_m;
            end
         end
         ST_ACTIVO: begin
            if (cnt_q == '0) begin
               state_d = ST_ENFRIAR;
               cnt_d   = c_enf;
               act_c_d = 1'b0;
               act_m_d = 1'b0;
               fin_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - c_uno;
            end
         end
         ST_ENFRIAR: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - c_uno;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            act_c_d = 1'b0;
            act_m_d = 1'b0;
         end
      endcase

      // A request on the grant edge re-arms the flag so it is served again.
      pend_c_d = (pend_c_q && !grant_c) || acepta_c;
      pend_m_d = (pend_m_q && !grant_m) || acepta_m;
      rech_d   = rechaza_c || rechaza_m;
      ocup_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ultimo_q <= c_ult_med;
         act_c_q  <= 1'b0;
         act_m_q  <= 1'b0;
         pend_c_q <= 1'b0;
         pend_m_q <= 1'b0;
         fin_q    <= 1'b0;
         rech_q   <= 1'b0;
         ocup_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ultimo_q <= ultimo_d;
         act_c_q  <= act_c_d;
         act_m_q  <= act_m_d;
         pend_c_q <= pend_c_d;
         pend_m_q <= pend_m_d;
         fin_q    <= fin_d;
         rech_q   <= rech_d;
         ocup_q   <= ocup_d;
      end
   end

   assign bus.Activo_Comida      = act_c_q;
   assign bus.Activo_Medicina    = act_m_q;
   assign bus.Ocupado            = ocup_q;
   assign bus.Fin_Accion         = fin_q;
   assign bus.Rechazo            = rech_q;
   assign bus.Pendiente_Comida   = pend_c_q;
   assign bus.Pendiente_Medicina = pend_m_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_acciones.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_acciones
// Description : Directed self-checking bench for arbitro_acciones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_acciones;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   arbitro_acciones_if bus_if ();

   arbitro_acciones #(
      .DURACION     (4),
      .ENFRIAMIENTO (2),
      .NIVEL_MAX    (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector order: {Activo_C, Activo_M, Ocupado, Fin, Rechazo, Pend_C, Pend_M}
   function automatic logic [6:0] salidas();
      return {bus_if.Activo_Comida, bus_if.Activo_Medicina, bus_if.Ocupado,
              bus_if.Fin_Accion, bus_if.Rechazo, bus_if.Pendiente_Comida,
              bus_if.Pendiente_Medicina};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] expected);
      logic [6:0] observed;
      observed = salidas();
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic do_reset(input int ciclos);
      reset = 1'b1;
      repeat (ciclos) step();
      reset = 1'b0;
   endtask

   // The two grants must never overlap.
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         assert (!(bus_if.Activo_Comida && bus_if.Activo_Medicina)) else begin
            errors++;
            $error("FAIL overlap observed=%b%b expected=not both",
                   bus_if.Activo_Comida, bus_if.Activo_Medicina);
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus_if.Req_Comida     = 1'b0;
      bus_if.Req_Medicina   = 1'b0;
      bus_if.Nivel_Comida   = 2'd0;
      bus_if.Nivel_Medicina = 2'd0;

      // 1: reset, then single food request
      do_reset(3);
      chk("t1_reset", 7'b0000000);
      step();
      chk("t1_idle", 7'b0000000);
      bus_if.Req_Comida   = 1'b1;
      bus_if.Nivel_Comida = 2'd1;
      step();
      bus_if.Req_Comida = 1'b0;
      chk("t1_pend", 7'b0000010);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_act", 7'b1010000);
      end
      step();
      chk("t1_fin", 7'b0011000);
      step();
      chk("t1_enf", 7'b0010000);
      step();
      chk("t1_idle2", 7'b0000000);

      // 2: simultaneous requests, food first, medicine 7 cycles later
      do_reset(1);
      bus_if.Nivel_Comida   = 2'd0;
      bus_if.Nivel_Medicina = 2'd0;
      bus_if.Req_Comida     = 1'b1;
      bus_if.Req_Medicina   = 1'b1;
      step();
      bus_if.Req_Comida   = 1'b0;
      bus_if.Req_Medicina = 1'b0;
      chk("t2_pend", 7'b0000011);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_act_c", 7'b1010001);
      end
      step();
      chk("t2_fin_c", 7'b0011001);
      step();
      chk("t2_enf_c", 7'b0010001);
      step();
      chk("t2_idle", 7'b0000001);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_act_m", 7'b0110000);
      end
      step();
      chk("t2_fin_m", 7'b0011000);
      step();
      chk("t2_enf_m", 7'b0010000);
      step();
      chk("t2_idle2", 7'b0000000);

      // 3: medicine request at max level is rejected
      bus_if.Nivel_Medicina = 2'd3;
      bus_if.Req_Medicina   = 1'b1;
      step();
      bus_if.Req_Medicina = 1'b0;
      chk("t3_rech", 7'b0000100);
      step();
      chk("t3_after", 7'b0000000);
      bus_if.Nivel_Medicina = 2'd0;

      // 4: repeated food request during its own grant
      bus_if.Req_Comida = 1'b1;
      step();
      bus_if.Req_Comida = 1'b0;
      chk("t4_pend", 7'b0000010);
      step();
      chk("t4_act1", 7'b1010000);
      bus_if.Req_Comida = 1'b1;
      step();
      bus_if.Req_Comida = 1'b0;
      chk("t4_act2", 7'b1010010);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t4_act34", 7'b1010010);
      end
      step();
      chk("t4_fin1", 7'b0011010);
      step();
      chk("t4_enf", 7'b0010010);
      step();
      chk("t4_idle", 7'b0000010);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_act_b", 7'b1010000);
      end
      step();
      chk("t4_fin2", 7'b0011000);
      step();
      chk("t4_enf2", 7'b0010000);
      step();
      chk("t4_idle2", 7'b0000000);

      // 5: reset during a medicine grant with food pending
      do_reset(1);
      bus_if.Req_Medicina = 1'b1;
      step();
      bus_if.Req_Medicina = 1'b0;
      chk("t5_pend", 7'b0000001);
      step();
      chk("t5_act1", 7'b0110000);
      bus_if.Req_Comida = 1'b1;
      step();
      bus_if.Req_Comida = 1'b0;
      chk("t5_act2", 7'b0110010);
      step();
      chk("t5_act3", 7'b0110010);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_reset", 7'b0000000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_quiet", 7'b0000000);
      end

      // 6: round-robin over three tie situations
      do_reset(1);
      bus_if.Req_Comida   = 1'b1;
      bus_if.Req_Medicina = 1'b1;
      step();
      bus_if.Req_Comida   = 1'b0;
      bus_if.Req_Medicina = 1'b0;
      chk("t6_tie1", 7'b0000011);
      step();
      chk("t6_grant_c", 7'b1010001);
      bus_if.Req_Comida = 1'b1;
      step();
      bus_if.Req_Comida = 1'b0;
      chk("t6_tie2_pend", 7'b1010011);
      repeat (5) step();
      chk("t6_tie2", 7'b0000011);
      step();
      chk("t6_grant_m", 7'b0110010);
      bus_if.Req_Medicina = 1'b1;
      step();
      bus_if.Req_Medicina = 1'b0;
      chk("t6_tie3_pend", 7'b0110011);
      repeat (5) step();
      chk("t6_tie3", 7'b0000011);
      step();
      chk("t6_grant_c2", 7'b1010001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
